// File: rtl/riscv_bp_pkg.sv
// Shared definitions for the branch predictor: counter states, indexing
// modes and a constant log2 helper used to size the table index.
package riscv_bp_pkg;

  // Named states of a 2-bit saturating counter
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt2_state_e;

  // Table indexing modes
  localparam int BP_BIMODAL = 0;
  localparam int BP_GSHARE  = 1;

  // Ceiling log2, evaluated at elaboration for IDX_W
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bpred_bht_if.sv
// Lookup, update and performance signals between the pipeline (master)
// and the branch history table (slave).
interface bpred_bht_if
  import riscv_bp_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int IDX_W  = 4,
  parameter int PERF_W = 16
);

  // IF-stage lookup
  logic [ADDR_W-1:0] lk_pc;
  logic              pred_taken;
  logic              pred_hit;
  logic [ADDR_W-1:0] pred_target;
  logic [IDX_W-1:0]  pred_idx;

  // ID-stage resolution
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispred;
  logic              tbl_clr;

  // Statistics
  logic [PERF_W-1:0] perf_br;
  logic [PERF_W-1:0] perf_miss;

  modport master (
    output lk_pc, upd_valid, upd_idx, upd_pc, upd_taken, upd_target,
           upd_mispred, tbl_clr,
    input  pred_taken, pred_hit, pred_target, pred_idx, perf_br, perf_miss
  );

  modport slave (
    input  lk_pc, upd_valid, upd_idx, upd_pc, upd_taken, upd_target,
           upd_mispred, tbl_clr,
    output pred_taken, pred_hit, pred_target, pred_idx, perf_br, perf_miss
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Next-state logic of an up/down saturating counter with a load value.
// Used once on the table update path.
module bp_sat_counter
  import riscv_bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_cur,
  input  logic             load,
  input  logic [CNT_W-1:0] init_val,
  input  logic             up,
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = '0;

  // Load on allocation, otherwise step toward the outcome and hold at the ends
  always_comb begin
    cnt_nxt = cnt_cur;
    if (load) begin
      cnt_nxt = init_val;
    end else if (up) begin
      if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != CNT_MIN) cnt_nxt = cnt_cur - CNT_W'(1);
    end
  end

endmodule

// File: rtl/bpred_bht.sv
// Branch history table with target buffer. Combinational lookup from the
// fetch word-address, single write-back port from ID, bimodal or gshare
// indexing, saturating resolved/mispredict counters.
module bpred_bht
  import riscv_bp_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int MODE    = BP_BIMODAL,
  parameter int HIST_W  = 4,
  parameter int PERF_W  = 16
) (
  input logic       clk,
  input logic       proc_reset,
  bpred_bht_if.slave bp
);

  localparam int IDX_W = clog2(ENTRIES);

  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));

  // Saturating increment for the statistics counters
  function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [HIST_W-1:0]  ghr_q;
  logic [PERF_W-1:0]  br_q;
  logic [PERF_W-1:0]  miss_q;

  logic [IDX_W-1:0]   lk_idx;
  logic               lk_hit;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic [CNT_W-1:0]   upd_init;
  logic [CNT_W-1:0]   upd_cnt_cur;
  logic [CNT_W-1:0]   upd_cnt_nxt;

  // Only the index and tag fields of the addresses take part in the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lk_pc, bp.upd_pc};

  // Lookup: index selection, tag compare and hit-gated outputs (no bypass)
  always_comb begin
    lk_idx = bp.lk_pc[IDX_W-1:0];
    if (MODE == BP_GSHARE) lk_idx = lk_idx ^ IDX_W'(ghr_q);
    lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == bp.lk_pc[IDX_W +: TAG_W]);
    bp.pred_idx    = lk_idx;
    bp.pred_hit    = lk_hit;
    bp.pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    bp.pred_target = lk_hit ? tgt_q[lk_idx] : '0;
  end

  // Update-side tag compare and counter seed for a fresh allocation
  always_comb begin
    upd_tag     = bp.upd_pc[IDX_W +: TAG_W];
    upd_hit     = valid_q[bp.upd_idx] && (tag_q[bp.upd_idx] == upd_tag);
    upd_init    = bp.upd_taken ? CNT_WT : CNT_WNT;
    upd_cnt_cur = cnt_q[bp.upd_idx];
  end

  bp_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .cnt_cur  (upd_cnt_cur),
    .load     (!upd_hit),
    .init_val (upd_init),
    .up       (bp.upd_taken),
    .cnt_nxt  (upd_cnt_nxt)
  );

  // Table entries; a clear wins over a same-cycle update and only drops valids
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_WNT;
      end
    end else if (bp.tbl_clr) begin
      valid_q <= '0;
    end else if (bp.upd_valid) begin
      valid_q[bp.upd_idx] <= 1'b1;
      tag_q[bp.upd_idx]   <= upd_tag;
      cnt_q[bp.upd_idx]   <= upd_cnt_nxt;
      if (!upd_hit || bp.upd_taken) tgt_q[bp.upd_idx] <= bp.upd_target;
    end
  end

  // Non-speculative global history, shifted only by resolved branches
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      ghr_q <= '0;
    end else if (bp.tbl_clr) begin
      ghr_q <= '0;
    end else if (bp.upd_valid && (MODE == BP_GSHARE)) begin
      ghr_q <= HIST_W'({ghr_q, bp.upd_taken});
    end
  end

  // Statistics count every resolution, including one dropped by a clear
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (bp.upd_valid) begin
      br_q <= perf_inc(br_q);
      if (bp.upd_mispred) miss_q <= perf_inc(miss_q);
    end
  end

  assign bp.perf_br   = br_q;
  assign bp.perf_miss = miss_q;

endmodule

// File: tb/tb_bpred_bht.sv
// Bench for bpred_bht: a bimodal instance (4-bit statistics) and a gshare
// instance share one stimulus stream and are compared every cycle with a
// table model written from the predictor's rules.
module tb_bpred_bht;

  localparam int ADDR_W  = 30;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 2;
  localparam int HIST_W  = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic proc_reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] d_pc, d_upc, d_utgt;
  logic [IDX_W-1:0]  d_uidx;
  logic              d_uv, d_ut, d_um, d_clr;

  bpred_bht_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .PERF_W(4))  bp0 ();
  bpred_bht_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .PERF_W(16)) bp1 ();

  assign bp0.lk_pc = d_pc;        assign bp1.lk_pc = d_pc;
  assign bp0.upd_valid = d_uv;    assign bp1.upd_valid = d_uv;
  assign bp0.upd_idx = d_uidx;    assign bp1.upd_idx = d_uidx;
  assign bp0.upd_pc = d_upc;      assign bp1.upd_pc = d_upc;
  assign bp0.upd_taken = d_ut;    assign bp1.upd_taken = d_ut;
  assign bp0.upd_target = d_utgt; assign bp1.upd_target = d_utgt;
  assign bp0.upd_mispred = d_um;  assign bp1.upd_mispred = d_um;
  assign bp0.tbl_clr = d_clr;     assign bp1.tbl_clr = d_clr;

  bpred_bht #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W),
              .MODE(0), .HIST_W(HIST_W), .PERF_W(4))
    dut0 (.clk(clk), .proc_reset(proc_reset), .bp(bp0));

  bpred_bht #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W),
              .MODE(1), .HIST_W(HIST_W), .PERF_W(16))
    dut1 (.clk(clk), .proc_reset(proc_reset), .bp(bp1));

  // Reference table: [instance][entry]
  bit mv   [2][ENTRIES];
  int mtag [2][ENTRIES];
  int mtgt [2][ENTRIES];
  int mcnt [2][ENTRIES];
  int mghr [2];
  int mbr  [2];
  int mmiss[2];
  int pmax [2] = '{15, 65535};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_tag(input int pc);
    return (pc / ENTRIES) % (1 << TAG_W);
  endfunction

  function automatic int m_idx(input int m, input int pc);
    int i;
    i = pc % ENTRIES;
    if (m == 1) i = i ^ mghr[1];
    return i;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mv[m][i] = 1'b0; mtag[m][i] = 0; mtgt[m][i] = 0;
        mcnt[m][i] = (1 << (CNT_W - 1)) - 1;
      end
      mghr[m] = 0; mbr[m] = 0; mmiss[m] = 0;
    end
  endtask

  task automatic model_step();
    int i, t;
    for (int m = 0; m < 2; m++) begin
      if (d_uv) begin
        if (mbr[m] < pmax[m]) mbr[m]++;
        if (d_um && mmiss[m] < pmax[m]) mmiss[m]++;
      end
      if (d_clr) begin
        for (int k = 0; k < ENTRIES; k++) mv[m][k] = 1'b0;
        mghr[m] = 0;
      end else if (d_uv) begin
        i = int'(d_uidx);
        t = m_tag(int'(d_upc));
        if (mv[m][i] && mtag[m][i] == t) begin
          if (d_ut) begin
            if (mcnt[m][i] < CMAX) mcnt[m][i]++;
            mtgt[m][i] = int'(d_utgt);
          end else if (mcnt[m][i] > 0) begin
            mcnt[m][i]--;
          end
        end else begin
          mv[m][i] = 1'b1;
          mtag[m][i] = t;
          mtgt[m][i] = int'(d_utgt);
          mcnt[m][i] = d_ut ? (1 << (CNT_W - 1)) : (1 << (CNT_W - 1)) - 1;
        end
        if (m == 1) mghr[m] = (mghr[m] * 2 + (d_ut ? 1 : 0)) % (1 << HIST_W);
      end
    end
  endtask

  task automatic chk_inst(input int m, input logic hit, input logic tk,
                          input logic [ADDR_W-1:0] tgt, input logic [IDX_W-1:0] idx,
                          input logic [15:0] br, input logic [15:0] miss);
    int  i;
    bit  h;
    i = m_idx(m, int'(d_pc));
    h = mv[m][i] && (mtag[m][i] == m_tag(int'(d_pc)));
    chk($sformatf("u%0d.pred_idx", m), 64'(idx), 64'(i));
    chk($sformatf("u%0d.pred_hit", m), 64'(hit), 64'(h));
    chk($sformatf("u%0d.pred_taken", m), 64'(tk), 64'(h && mcnt[m][i] >= (1 << (CNT_W - 1))));
    chk($sformatf("u%0d.pred_target", m), 64'(tgt), h ? 64'(mtgt[m][i]) : 64'(0));
    chk($sformatf("u%0d.perf_br", m), 64'(br), 64'(mbr[m]));
    chk($sformatf("u%0d.perf_miss", m), 64'(miss), 64'(mmiss[m]));
  endtask

  task automatic check_all();
    chk_inst(0, bp0.pred_hit, bp0.pred_taken, bp0.pred_target, bp0.pred_idx,
             16'(bp0.perf_br), 16'(bp0.perf_miss));
    chk_inst(1, bp1.pred_hit, bp1.pred_taken, bp1.pred_target, bp1.pred_idx,
             bp1.perf_br, bp1.perf_miss);
  endtask

  task automatic drive(input int pc, input int uv, input int uidx, input int upc,
                       input int ut, input int utgt, input int um, input int clr);
    @(negedge clk);
    d_pc = ADDR_W'(pc); d_uv = (uv != 0); d_uidx = IDX_W'(uidx); d_upc = ADDR_W'(upc);
    d_ut = (ut != 0); d_utgt = ADDR_W'(utgt); d_um = (um != 0); d_clr = (clr != 0);
    #1;
    check_all();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input int pc, input int uv, input int uidx, input int upc,
                     input int ut, input int utgt, input int um, input int clr);
    drive(pc, uv, uidx, upc, ut, utgt, um, clr);
    end_cycle();
  endtask

  task automatic look(input int pc);
    drive(pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle();
    int pc, upc, uidx;
    pc   = int'($urandom_range(0, 47));
    upc  = int'($urandom_range(0, 47));
    if ($urandom_range(0, 3) == 0) upc = upc | (int'($urandom_range(1, 255)) << 12);
    uidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : upc % ENTRIES;
    cyc(pc, int'($urandom_range(0, 3) != 0), uidx, upc, int'($urandom_range(0, 1)),
        int'($urandom & 32'h3FFF_FFFF), int'($urandom_range(0, 1)),
        int'($urandom_range(0, 49) == 0));
  endtask

  initial begin
    proc_reset = 1'b1;
    d_pc = '0; d_upc = '0; d_utgt = '0; d_uidx = '0;
    d_uv = 1'b0; d_ut = 1'b0; d_um = 1'b0; d_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    proc_reset = 1'b0;

    // Reset state
    look(32'h10);
    chk("rst.hit", 64'(bp0.pred_hit), 64'(0));
    chk("rst.taken", 64'(bp0.pred_taken), 64'(0));
    chk("rst.target", 64'(bp0.pred_target), 64'(0));
    chk("rst.idx", 64'(bp0.pred_idx), 64'(0));
    chk("rst.perf_br", 64'(bp1.perf_br), 64'(0));
    chk("rst.perf_miss", 64'(bp1.perf_miss), 64'(0));
    end_cycle();

    // Allocate 0x25 taken, then look it up and a same-index different tag
    cyc(0, 1, 5, 32'h25, 1, 32'h40, 0, 0);
    look(32'h25);
    chk("alloc.hit", 64'(bp0.pred_hit), 64'(1));
    chk("alloc.taken", 64'(bp0.pred_taken), 64'(1));
    chk("alloc.target", 64'(bp0.pred_target), 64'(32'h40));
    end_cycle();
    look(32'h35);
    chk("alias.hit", 64'(bp0.pred_hit), 64'(0));
    end_cycle();

    // Counter saturation in both directions; not-taken keeps the old target
    repeat (4) cyc(0, 1, 5, 32'h25, 1, 32'h40, 0, 0);
    cyc(0, 1, 5, 32'h25, 0, 32'h77, 0, 0);
    look(32'h25);
    chk("sat.at2_taken", 64'(bp0.pred_taken), 64'(1));
    end_cycle();
    repeat (3) cyc(0, 1, 5, 32'h25, 0, 32'h77, 0, 0);
    look(32'h25);
    chk("sat.low_taken", 64'(bp0.pred_taken), 64'(0));
    chk("sat.low_hit", 64'(bp0.pred_hit), 64'(1));
    chk("sat.keep_target", 64'(bp0.pred_target), 64'(32'h40));
    end_cycle();
    cyc(0, 1, 5, 32'h25, 0, 32'h77, 0, 0);
    cyc(0, 1, 5, 32'h25, 1, 32'h40, 0, 0);
    look(32'h25);
    chk("sat.floor_taken", 64'(bp0.pred_taken), 64'(0));
    end_cycle();
    cyc(0, 1, 5, 32'h25, 1, 32'h40, 0, 0);
    look(32'h25);
    chk("sat.recover_taken", 64'(bp0.pred_taken), 64'(1));
    end_cycle();

    // Global history: T, T, NT gives 0110 so 0x03 indexes 0x5
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    look(32'h03);
    chk("ghr.clr_idx", 64'(bp1.pred_idx), 64'(3));
    end_cycle();
    cyc(0, 1, 1, 32'h01, 1, 32'h11, 0, 0);
    cyc(0, 1, 2, 32'h02, 1, 32'h12, 0, 0);
    cyc(0, 1, 7, 32'h07, 0, 32'h17, 0, 0);
    look(32'h03);
    chk("ghr.gshare_idx", 64'(bp1.pred_idx), 64'(5));
    chk("ghr.bimodal_idx", 64'(bp0.pred_idx), 64'(3));
    end_cycle();
    look(32'h01);
    chk("ghr.pre_clr_hit", 64'(bp0.pred_hit), 64'(1));
    end_cycle();
    // Clear together with an update: the update is dropped but counted
    cyc(0, 1, 9, 32'h09, 1, 32'h19, 1, 1);
    for (int i = 0; i < ENTRIES; i++) begin
      look(i);
      chk($sformatf("clr.u0_hit%0d", i), 64'(bp0.pred_hit), 64'(0));
      chk($sformatf("clr.u1_hit%0d", i), 64'(bp1.pred_hit), 64'(0));
      chk($sformatf("clr.u1_idx%0d", i), 64'(bp1.pred_idx), 64'(i));
      end_cycle();
    end

    // Same-cycle update and lookup at index 2 sees the old entry
    drive(32'h02, 1, 2, 32'h02, 1, 32'h50, 0, 0);
    chk("nobyp.u0_hit", 64'(bp0.pred_hit), 64'(0));
    chk("nobyp.u1_hit", 64'(bp1.pred_hit), 64'(0));
    end_cycle();
    look(32'h02);
    chk("nobyp.next_hit", 64'(bp0.pred_hit), 64'(1));
    chk("nobyp.next_target", 64'(bp0.pred_target), 64'(32'h50));
    end_cycle();

    // 4-bit statistics saturate at 15
    for (int k = 0; k < 20; k++) cyc(0, 1, k % ENTRIES, k, k % 2, k, 1, 0);
    look(0);
    chk("perf4.br", 64'(bp0.perf_br), 64'(15));
    chk("perf4.miss", 64'(bp0.perf_miss), 64'(15));
    end_cycle();

    // Mispredict flag without upd_valid is ignored
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    repeat (600) rand_cycle();

    // Asynchronous reset asserted between edges
    cyc(0, 1, 5, 32'h25, 1, 32'h40, 1, 0);
    look(32'h25);
    chk("arst.pre_hit", 64'(bp0.pred_hit), 64'(1));
    #1;
    proc_reset = 1'b1;
    #1;
    chk("arst.u0_hit", 64'(bp0.pred_hit), 64'(0));
    chk("arst.u0_taken", 64'(bp0.pred_taken), 64'(0));
    chk("arst.u0_target", 64'(bp0.pred_target), 64'(0));
    chk("arst.u0_idx", 64'(bp0.pred_idx), 64'(5));
    chk("arst.u1_idx", 64'(bp1.pred_idx), 64'(5));
    chk("arst.u1_hit", 64'(bp1.pred_hit), 64'(0));
    chk("arst.u0_perf_br", 64'(bp0.perf_br), 64'(0));
    chk("arst.u1_perf_br", 64'(bp1.perf_br), 64'(0));
    chk("arst.u1_perf_miss", 64'(bp1.perf_miss), 64'(0));
    model_reset();
    end_cycle();
    @(negedge clk);
    proc_reset = 1'b0;
    repeat (60) rand_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpred_bht.md
Name: bpred_bht

Overview:
- Parametrised branch history table with a branch target buffer, for the 5-stage RISCV_Pipeline.
- Replaces the single-counter branch predictor.
- IF stage performs a combinational lookup on the fetch word-address; ID stage writes back the resolved outcome one or more cycles later.
- MODE selects plain bimodal indexing or gshare (PC XOR global history). Saturating performance counters record lookups-resolved and mispredictions.

Parameters:
- ADDR_W, 30: word-address width (same as ICACHE_addr).
- ENTRIES, 16: table depth; power of two, 4..256. IDX_W = log2(ENTRIES).
- TAG_W, 8: stored tag bits, taken from pc[IDX_W +: TAG_W]; IDX_W+TAG_W <= ADDR_W.
- CNT_W, 2: saturating counter width, 1..4.
- MODE, 0: 0 = bimodal, 1 = gshare.
- HIST_W, 4: global history length, 1..IDX_W; unused when MODE=0.
- PERF_W, 16: performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- lk_pc  in  ADDR_W  IF-stage fetch word-address.
- pred_taken  out  1  predict taken (hit AND counter MSB = 1).
- pred_hit  out  1  valid entry with matching tag.
- pred_target  out  ADDR_W  stored target; 0 when no hit.
- pred_idx  out  IDX_W  index used for lookup; the pipeline carries it to ID.
- upd_valid  in  1  one resolved conditional branch this cycle.
- upd_idx  in  IDX_W  pred_idx carried with the branch.
- upd_pc  in  ADDR_W  branch word-address, used for the tag.
- upd_taken  in  1  actual outcome (equal_or_not).
- upd_target  in  ADDR_W  resolved target word-address.
- upd_mispred  in  1  pipeline flushed for this branch.
- tbl_clr  in  1  synchronous clear of all valid bits and the history register.
- perf_br  out  PERF_W  resolved branch count, saturating.
- perf_miss  out  PERF_W  mispredict count, saturating.

Behaviour:
- Reset (asynchronous, effective immediately, including mid-update):
  - all valid=0, all counters = weakly-not-taken (2^(CNT_W-1)-1; 01 for CNT_W=2), tags/targets=0.
  - ghr=0, perf_br=perf_miss=0.
  - Outputs while in reset: pred_taken=0, pred_hit=0, pred_target=0; pred_idx follows lk_pc.
- Lookup is purely combinational from registered state; zero latency.
  - MODE=0: idx = lk_pc[IDX_W-1:0].
  - MODE=1: idx = lk_pc[IDX_W-1:0] XOR zero-extended ghr[HIST_W-1:0].
  - hit = valid[idx] AND tag[idx] == lk_pc[IDX_W +: TAG_W].
- Update, on a clock edge with upd_valid=1 at index upd_idx:
  - Hit (valid and tag equal to upd_pc's tag): counter +1 if taken, saturating at 2^CNT_W-1; -1 if not taken, saturating at 0. Target overwritten only when taken.
  - Miss (allocate or replace): valid=1, tag written, target=upd_target. Counter = weakly-taken (2^(CNT_W-1)) if taken, else weakly-not-taken.
  - ghr <= {ghr[HIST_W-2:0], upd_taken}; only for MODE=1, only on upd_valid. History is non-speculative.
  - perf_br +1; perf_miss +1 if upd_mispred. Both hold at all-ones (no wrap).
- No lookup/update bypass: a lookup in the same cycle as an update to the same index sees the pre-update entry.
- tbl_clr:
  - Clears valid bits and ghr; counters, tags, targets and perf counters are untouched.
  - Priority over upd_valid in the same cycle; that update is dropped but still counted in perf.
- upd_mispred with upd_valid=0 is ignored.
- Single update port; the pipeline guarantees at most one resolution per cycle.
- No handshake and no stall input: the caller gates upd_valid during DCACHE/ICACHE stalls.

Decomposition:
- Shared package riscv_bp_pkg:
  - counter-state constants (SNT, WNT, WT, ST for CNT_W=2);
  - MODE encodings (BP_BIMODAL=0, BP_GSHARE=1);
  - a function clog2 for IDX_W.
- One sub-module, bp_sat_counter: CNT_W-wide up/down saturating counter next-state logic with init-value input.
  - Instantiate combinationally once on the update path; not one per entry.

Test Plan:
- Reset then lk_pc=0x10 -> pred_hit=0, pred_taken=0, pred_target=0, pred_idx=0; perf_br=perf_miss=0.
- MODE=0: update pc=0x25 taken target=0x40, then lookup 0x25 -> hit=1, taken=1, target=0x40.
  - Lookup 0x35 (same idx 5, different tag) -> hit=0.
- Saturation: 4 taken updates on one entry -> counter=3; 4 not-taken -> counter=0, pred_taken=0.
  - A fifth not-taken leaves it at 0.
- MODE=1, HIST_W=4: updates taken, taken, not-taken -> ghr=0b0110.
  - lk_pc=0x03 -> pred_idx=0x5.
  - tbl_clr -> ghr=0, pred_hit=0 for every index.
- Same-cycle update and lookup at idx 2 (first allocation) -> pred_hit=0 that cycle, 1 the next.
- perf: PERF_W=4, 20 updates all with upd_mispred=1 -> perf_br=perf_miss=15.
  - Assert proc_reset mid-cycle -> all outputs return to reset values before the next edge.
